sram_dp_clear: RTL and testbench

SRAM_DP_CLEAR -- requirements
Module: sram_dp_clear

---
 rtl/sram_dp_clear.sv | 143 ++++++++++++++
 tb/tb_sram_dp_clear.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_clear.sv
// Two-port (2R + 2W) lane-masked SRAM with a sequential clear engine.
// A clear sweeps CLEAR_VALUE through every word, one address per cycle, while all user traffic is held off.
module sram_dp_clear #(
    parameter int                 D_WIDTH        = 8,
    parameter int                 A_WIDTH        = 8,
    parameter int                 TOTAL_WORDS    = 0,
    parameter int                 LANE_WIDTH     = 8,
    parameter int                 OUT_REG        = 0,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [D_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                LANES          = D_WIDTH / LANE_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_req,
    output logic               busy,
    output logic               state_dbg,
    input  logic [A_WIDTH-1:0] read_addr_a,
    input  logic [A_WIDTH-1:0] read_addr_b,
    input  logic               read_en_a,
    input  logic               read_en_b,
    output logic [D_WIDTH-1:0] read_a,
    output logic [D_WIDTH-1:0] read_b,
    output logic               read_valid_a,
    output logic               read_valid_b,
    input  logic [A_WIDTH-1:0] write_addr_a,
    input  logic [A_WIDTH-1:0] write_addr_b,
    input  logic               write_en_a,
    input  logic               write_en_b,
    input  logic [LANES-1:0]   write_mask_a,
    input  logic [LANES-1:0]   write_mask_b,
    input  logic [D_WIDTH-1:0] write_a,
    input  logic [D_WIDTH-1:0] write_b
);
    localparam int NUM_ADDR = (TOTAL_WORDS == 0) ? (1 << A_WIDTH) : TOTAL_WORDS;
    localparam int IW       = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam logic [A_WIDTH:0]   NUM_ADDR_W = (A_WIDTH + 1)'(NUM_ADDR);
    localparam logic [A_WIDTH-1:0] LAST_ADDR  = A_WIDTH'(NUM_ADDR - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t               state, state_nxt;
    logic                 start_pend;
    logic [A_WIDTH-1:0]   clr_addr;
    logic                 last_addr;
    logic                 idle;
    logic [D_WIDTH-1:0]   mem [NUM_ADDR];
    logic [D_WIDTH-1:0]   d1_a, d1_b, d2_a, d2_b;
    logic                 v1_a, v1_b, v2_a, v2_b;

    function automatic logic in_range(input logic [A_WIDTH-1:0] addr);
        return {1'b0, addr} < NUM_ADDR_W;
    endfunction

    function automatic logic [D_WIDTH-1:0] rd_word(input logic [A_WIDTH-1:0] addr);
        return in_range(addr) ? mem[addr[IW-1:0]] : '0;
    endfunction

    assign last_addr = (clr_addr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req || start_pend) state_nxt = CLEAR;
            CLEAR:   if (last_addr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CLEAR);
        idle      = (state == IDLE);
        state_dbg = state;
    end

    // start_pend turns the first edge after reset release into a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend <= (CLEAR_ON_RESET != 0);
            clr_addr   <= '0;
        end else begin
            start_pend <= 1'b0;
            if (state == CLEAR) clr_addr <= last_addr ? '0 : clr_addr + 1'b1;
        end
    end

    // Port B lanes are written first so that port A overrides on shared lanes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr[IW-1:0]] <= CLEAR_VALUE;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (write_en_b && write_mask_b[l] && in_range(write_addr_b))
                    mem[write_addr_b[IW-1:0]][l*LANE_WIDTH +: LANE_WIDTH] <= write_b[l*LANE_WIDTH +: LANE_WIDTH];
                if (write_en_a && write_mask_a[l] && in_range(write_addr_a))
                    mem[write_addr_a[IW-1:0]][l*LANE_WIDTH +: LANE_WIDTH] <= write_a[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_a <= 1'b0;
            v1_b <= 1'b0;
            d1_a <= '0;
            d1_b <= '0;
        end else begin
            v1_a <= read_en_a && idle;
            v1_b <= read_en_b && idle;
            if (read_en_a && idle) d1_a <= rd_word(read_addr_a);
            if (read_en_b && idle) d1_b <= rd_word(read_addr_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_a <= 1'b0;
            v2_b <= 1'b0;
            d2_a <= '0;
            d2_b <= '0;
        end else begin
            v2_a <= v1_a;
            v2_b <= v1_b;
            if (v1_a) d2_a <= d1_a;
            if (v1_b) d2_b <= d1_b;
        end
    end

    always_comb begin
        read_a       = (OUT_REG != 0) ? d2_a : d1_a;
        read_b       = (OUT_REG != 0) ? d2_b : d1_b;
        read_valid_a = (OUT_REG != 0) ? v2_a : v1_a;
        read_valid_b = (OUT_REG != 0) ? v2_b : v1_b;
    end
endmodule

// File: tb/tb_sram_dp_clear.sv
// Bench for sram_dp_clear: two instances (full depth / no out reg, 12 words / out reg) on shared stimulus,
// checked every cycle against an array-and-queue model of the memory.
module tb_sram_dp_clear;
    localparam int          DW = 16;
    localparam int          AW = 4;
    localparam logic [15:0] CV = 16'hA5A5;

    typedef struct {
        int          due;
        int          key;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear_req = 1'b0;
    logic [AW-1:0] ra_a = '0, ra_b = '0, wa_a = '0, wa_b = '0;
    logic          re_a = 1'b0, re_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [1:0]    wm_a = '0, wm_b = '0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;

    logic          busy0, busy1, st0, st1;
    logic [DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic          rv_a0, rv_b0, rv_a1, rv_b1;

    logic [15:0]   mm [2][16];
    int            clr_left [2];
    int            num [2] = '{16, 12};
    int            lat [2] = '{0, 1};
    bit            pend;
    exp_t          exp_q [$];
    logic [15:0]   last_d [4];
    int            cyc;
    int            n_checks;
    int            n_pass;

    sram_dp_clear #(
        .D_WIDTH(DW), .A_WIDTH(AW), .TOTAL_WORDS(0), .LANE_WIDTH(8),
        .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0), .state_dbg(st0),
        .read_addr_a(ra_a), .read_addr_b(ra_b), .read_en_a(re_a), .read_en_b(re_b),
        .read_a(rd_a0), .read_b(rd_b0), .read_valid_a(rv_a0), .read_valid_b(rv_b0),
        .write_addr_a(wa_a), .write_addr_b(wa_b), .write_en_a(we_a), .write_en_b(we_b),
        .write_mask_a(wm_a), .write_mask_b(wm_b), .write_a(wd_a), .write_b(wd_b)
    );

    sram_dp_clear #(
        .D_WIDTH(DW), .A_WIDTH(AW), .TOTAL_WORDS(12), .LANE_WIDTH(8),
        .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1), .state_dbg(st1),
        .read_addr_a(ra_a), .read_addr_b(ra_b), .read_en_a(re_a), .read_en_b(re_b),
        .read_a(rd_a1), .read_b(rd_b1), .read_valid_a(rv_a1), .read_valid_b(rv_b1),
        .write_addr_a(wa_a), .write_addr_b(wa_b), .write_en_a(we_a), .write_en_b(we_b),
        .write_mask_a(wm_a), .write_mask_b(wm_b), .write_a(wd_a), .write_b(wd_b)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    function automatic logic [15:0] model_rd(input int i, input logic [AW-1:0] a);
        return (int'(a) < num[i]) ? mm[i][a] : 16'h0000;
    endfunction

    task automatic model_write(input int i, input logic [AW-1:0] a, input logic [1:0] m, input logic [15:0] d);
        if (int'(a) < num[i])
            for (int l = 0; l < 2; l++)
                if (m[l]) mm[i][a][l*8 +: 8] = d[l*8 +: 8];
    endtask

    // What the next rising edge does to each memory, from the current inputs.
    task automatic model_edge();
        int e;
        e = cyc + 1;
        if (!rst_n) return;
        for (int i = 0; i < 2; i++) begin
            if (clr_left[i] > 0) begin
                mm[i][num[i] - clr_left[i]] = CV;
                clr_left[i]--;
            end else begin
                if (re_a) exp_q.push_back('{due: e + lat[i], key: 2*i,     data: model_rd(i, ra_a)});
                if (re_b) exp_q.push_back('{due: e + lat[i], key: 2*i + 1, data: model_rd(i, ra_b)});
                if (we_b) model_write(i, wa_b, wm_b, wd_b);
                if (we_a) model_write(i, wa_a, wm_a, wd_a);
                if (clear_req || pend) clr_left[i] = num[i];
            end
        end
        pend = 1'b0;
    endtask

    task automatic check_outputs();
        logic        got_v;
        logic [15:0] got_d;
        logic        ev;
        int          idx;
        for (int k = 0; k < 4; k++) begin
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++)
                if (idx < 0 && exp_q[j].key == k && exp_q[j].due == cyc) idx = j;
            ev = (idx >= 0);
            if (ev) begin
                last_d[k] = exp_q[idx].data;
                exp_q.delete(idx);
            end
            case (k)
                0:       begin got_v = rv_a0; got_d = rd_a0; end
                1:       begin got_v = rv_b0; got_d = rd_b0; end
                2:       begin got_v = rv_a1; got_d = rd_a1; end
                default: begin got_v = rv_b1; got_d = rd_b1; end
            endcase
            check($sformatf("valid%0d", k), 32'(got_v), 32'(ev));
            check($sformatf("data%0d", k), 32'(got_d), 32'(last_d[k]));
        end
        check("busy0", 32'(busy0), 32'(clr_left[0] > 0));
        check("busy1", 32'(busy1), 32'(clr_left[1] > 0));
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge with enables idled.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        @(negedge clk);
        re_a = 1'b0; re_b = 1'b0; we_a = 1'b0; we_b = 1'b0; clear_req = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        pend  = 1'b1;
        clr_left[0] = 0;
        clr_left[1] = 0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) last_d[k] = '0;
        for (int c = 0; c < cycles; c++) step();
        rst_n = 1'b1;
    endtask

    // Counts busy0 cycles after reset release, optionally pulsing clear_req mid-clear.
    task automatic count_busy(input string tag, input int pulse_at);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == pulse_at) clear_req = 1'b1;
            step();
            if (busy0) cnt++;
            else if (cnt > 0) break;
        end
        check(tag, 32'(cnt), 32'd16);
    endtask

    task automatic wr(input bit port_b, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        if (port_b) begin we_b = 1'b1; wa_b = a; wd_b = d; wm_b = m; end
        else        begin we_a = 1'b1; wa_a = a; wd_a = d; wm_a = m; end
    endtask

    task automatic rd(input bit port_b, input logic [AW-1:0] a);
        if (port_b) begin re_b = 1'b1; ra_b = a; end
        else        begin re_a = 1'b1; ra_a = a; end
    endtask

    initial begin
        logic [15:0] v [4];
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        #2;
        do_reset(2);
        count_busy("init_busy_len", -1);

        for (int a = 0; a < 16; a++) begin
            rd(0, AW'(a));
            step();
            check("clr_valid", 32'(rv_a0), 32'd1);
            check("clr_data", 32'(rd_a0), 32'(CV));
        end

        wr(0, 4'd3, 16'h1234, 2'b11); step();
        wr(1, 4'd3, 16'hFFEE, 2'b01); step();
        rd(0, 4'd3); step();
        check("seq_mask", 32'(rd_a0), 32'h12EE);

        wr(0, 4'd5, 16'h1111, 2'b01); wr(1, 4'd5, 16'h2222, 2'b11); step();
        rd(0, 4'd5); step();
        check("coll_lo", 32'(rd_a0), 32'h2211);
        wr(0, 4'd5, 16'h1111, 2'b11); wr(1, 4'd5, 16'h2222, 2'b11); step();
        rd(0, 4'd5); step();
        check("coll_all", 32'(rd_a0), 32'h1111);

        wr(0, 4'd7, 16'h0007, 2'b11); step();
        wr(0, 4'd7, 16'h0070, 2'b11); rd(1, 4'd7); step();
        check("rdw_old", 32'(rd_b0), 32'h0007);
        rd(1, 4'd7); step();
        check("rdw_new", 32'(rd_b0), 32'h0070);

        for (int a = 0; a < 4; a++) v[a] = mm[1][a];
        for (int k = 0; k < 6; k++) begin
            if (k < 4) rd(0, AW'(k));
            step();
            check("oreg_valid", 32'(rv_a1), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) check("oreg_data", 32'(rd_a1), 32'(v[k-1]));
        end

        for (int c = 0; c < 400; c++) begin
            re_a = 1'($urandom_range(0, 1)); ra_a = AW'($urandom_range(0, 15));
            re_b = 1'($urandom_range(0, 1)); ra_b = AW'($urandom_range(0, 15));
            we_a = 1'($urandom_range(0, 1)); wa_a = AW'($urandom_range(0, 15));
            we_b = 1'($urandom_range(0, 1)); wa_b = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wa_b = wa_a;
            if ($urandom_range(0, 3) == 0) ra_a = wa_a;
            wm_a = 2'($urandom_range(0, 3)); wm_b = 2'($urandom_range(0, 3));
            wd_a = 16'($urandom); wd_b = 16'($urandom);
            clear_req = ($urandom_range(0, 59) == 0);
            step();
        end

        for (int c = 0; c < 40 && (busy0 || busy1); c++) step();
        check("idle_before_abort", 32'({busy0, busy1}), 32'd0);
        clear_req = 1'b1;
        step();
        for (int c = 0; c < 8; c++) step();
        do_reset(2);
        count_busy("abort_busy_len", 5);

        for (int a = 0; a < 16; a++) begin
            rd(0, AW'(a)); rd(1, AW'(15 - a));
            step();
        end
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
